// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the inter-stage pipeline registers: state encoding
// and per-stage payload widths (packing stays in each stage).
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        PSR_EMPTY = 2'b00,
        PSR_ONE   = 2'b01,
        PSR_TWO   = 2'b11
    } psr_state_e;

    localparam int unsigned IF_ID_PAYLOAD_W  = 64;
    localparam int unsigned ID_EX_PAYLOAD_W  = 168;
    localparam int unsigned EX_MEM_PAYLOAD_W = 136;
    localparam int unsigned MEM_WB_PAYLOAD_W = 104;

    function automatic logic psr_main_v(input psr_state_e s);
        return s != PSR_EMPTY;
    endfunction

    function automatic logic psr_skid_v(input psr_state_e s);
        return s == PSR_TWO;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle carrying a payload and its side-band bits.
interface pipe_skid_reg_if #(
    parameter int unsigned DATA_W   = 136,
    parameter int unsigned STICKY_W = 2
);
    logic                valid;
    logic                ready;
    logic [DATA_W-1:0]   data;
    logic [STICKY_W-1:0] sticky;

    modport master (output valid, output data, output sticky, input ready);
    modport slave  (input valid, input data, input sticky, output ready);
endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline boundary register with a two-entry skid buffer so up.ready never
// depends combinationally on dn.ready; flush kills entries, sticky bits survive.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W       = 136,
    parameter int unsigned STICKY_W     = 2,
    parameter bit          CLR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_en,
    input  logic               flush,
    pipe_skid_reg_if.slave     up,
    pipe_skid_reg_if.master    dn,
    output logic               skid_full,
    output logic [CNT_W-1:0]   stall_cnt,
    input  logic               stall_cnt_clr
);
    psr_state_e          st_q, st_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [STICKY_W-1:0] main_sticky_q, main_sticky_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [STICKY_W-1:0] skid_sticky_q, skid_sticky_d;
    logic                rdy_q, rdy_d;

    logic main_v;
    logic acc;
    logic pop;
    logic kill;

    assign main_v = psr_main_v(st_q);
    assign kill   = cpu_en & flush;
    assign acc    = cpu_en & up.valid & up.ready & ~flush;
    assign pop    = cpu_en & main_v & dn.ready & ~flush;

    always_comb begin
        st_d          = st_q;
        main_data_d   = main_data_q;
        main_sticky_d = main_sticky_q;
        skid_data_d   = skid_data_q;
        skid_sticky_d = skid_sticky_q;
        if (kill) begin
            st_d          = PSR_EMPTY;
            skid_sticky_d = '0;
            if (CLR_ON_FLUSH) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (st_q)
                PSR_EMPTY: begin
                    if (acc) begin
                        st_d          = PSR_ONE;
                        main_data_d   = up.data;
                        main_sticky_d = up.sticky;
                    end
                end
                PSR_ONE: begin
                    if (acc && pop) begin
                        main_data_d   = up.data;
                        main_sticky_d = up.sticky;
                    end else if (acc) begin
                        st_d          = PSR_TWO;
                        skid_data_d   = up.data;
                        skid_sticky_d = up.sticky;
                    end else if (pop) begin
                        st_d = PSR_EMPTY;
                    end
                end
                PSR_TWO: begin
                    // up.ready is low here, so only a pop can move the state
                    if (pop) begin
                        st_d          = PSR_ONE;
                        main_data_d   = skid_data_q;
                        main_sticky_d = skid_sticky_q;
                    end
                end
                default: st_d = PSR_EMPTY;
            endcase
        end
        rdy_d = ~psr_skid_v(st_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q          <= PSR_EMPTY;
            main_data_q   <= '0;
            main_sticky_q <= '0;
            skid_data_q   <= '0;
            skid_sticky_q <= '0;
            rdy_q         <= 1'b0;
        end else begin
            st_q          <= st_d;
            main_data_q   <= main_data_d;
            main_sticky_q <= main_sticky_d;
            skid_data_q   <= skid_data_d;
            skid_sticky_q <= skid_sticky_d;
            rdy_q         <= rdy_d;
        end
    end

    assign up.ready  = cpu_en & rdy_q;
    assign dn.valid  = main_v;
    assign dn.data   = main_data_q;
    assign dn.sticky = main_sticky_q;
    assign skid_full = psr_skid_v(st_q);

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cpu_en & main_v & ~dn.ready & ~flush),
        .clr   (cpu_en & stall_cnt_clr),
        .cnt   (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench: instance A clears payload on flush with a 16-bit counter,
// instance B holds payload on flush with a 4-bit counter.
module tb_pipe_skid_reg;
    logic        clk;
    logic        rst_n;
    logic        cpu_en_a, flush_a, clr_a;
    logic        cpu_en_b, flush_b, clr_b;
    logic        skid_full_a, skid_full_b;
    logic [15:0] stall_a;
    logic [3:0]  stall_b;

    int unsigned vectors;
    int unsigned miscompares;

    pipe_skid_reg_if #(.DATA_W(16), .STICKY_W(2)) ua ();
    pipe_skid_reg_if #(.DATA_W(16), .STICKY_W(2)) da ();
    pipe_skid_reg_if #(.DATA_W(16), .STICKY_W(2)) ub ();
    pipe_skid_reg_if #(.DATA_W(16), .STICKY_W(2)) db ();

    pipe_skid_reg #(.DATA_W(16), .STICKY_W(2), .CLR_ON_FLUSH(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en_a), .flush(flush_a),
        .up(ua), .dn(da), .skid_full(skid_full_a),
        .stall_cnt(stall_a), .stall_cnt_clr(clr_a)
    );

    pipe_skid_reg #(.DATA_W(16), .STICKY_W(2), .CLR_ON_FLUSH(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en_b), .flush(flush_b),
        .up(ub), .dn(db), .skid_full(skid_full_b),
        .stall_cnt(stall_b), .stall_cnt_clr(clr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
        chk("a_no_orphan_skid", {63'd0, skid_full_a & ~da.valid}, 64'd0);
        chk("b_no_orphan_skid", {63'd0, skid_full_b & ~db.valid}, 64'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        cpu_en_a = 1'b1; flush_a = 1'b0; clr_a = 1'b0;
        cpu_en_b = 1'b1; flush_b = 1'b0; clr_b = 1'b0;
        ua.valid = 1'b0; ua.data = '0; ua.sticky = '0; da.ready = 1'b1;
        ub.valid = 1'b0; ub.data = '0; ub.sticky = '0; db.ready = 1'b1;

        // reset held 3 cycles
        tick(); tick(); tick();
        chk("rst_a_dn_valid", {63'd0, da.valid}, 64'd0);
        chk("rst_a_dn_data", {48'd0, da.data}, 64'd0);
        chk("rst_a_dn_sticky", {62'd0, da.sticky}, 64'd0);
        chk("rst_a_skid_full", {63'd0, skid_full_a}, 64'd0);
        chk("rst_a_stall", {48'd0, stall_a}, 64'd0);
        chk("rst_a_up_ready", {63'd0, ua.ready}, 64'd0);
        chk("rst_b_up_ready", {63'd0, ub.ready}, 64'd0);
        chk("rst_b_stall", {60'd0, stall_b}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_a_up_ready", {63'd0, ua.ready}, 64'd1);

        // streaming at full throughput
        for (int i = 1; i <= 4; i++) begin
            ua.valid = 1'b1;
            ua.data  = 16'(i);
            tick();
            chk("stream_dn_valid", {63'd0, da.valid}, 64'd1);
            chk("stream_dn_data", {48'd0, da.data}, 64'(i));
            chk("stream_up_ready", {63'd0, ua.ready}, 64'd1);
        end
        ua.valid = 1'b0;
        tick();
        chk("stream_drained", {63'd0, da.valid}, 64'd0);
        chk("stream_stall", {48'd0, stall_a}, 64'd0);

        // backpressure into the skid entry
        ua.valid = 1'b1; ua.data = 16'h000A;
        tick();
        chk("bp_first", {48'd0, da.data}, 64'h0A);
        da.ready = 1'b0; ua.data = 16'h000B;
        tick();
        chk("bp_main_a", {48'd0, da.data}, 64'h0A);
        chk("bp_skid_full", {63'd0, skid_full_a}, 64'd1);
        chk("bp_up_ready", {63'd0, ua.ready}, 64'd0);
        chk("bp_stall1", {48'd0, stall_a}, 64'd1);
        ua.data = 16'h000C;
        tick();
        tick();
        chk("bp_hold_a", {48'd0, da.data}, 64'h0A);
        chk("bp_stall3", {48'd0, stall_a}, 64'd3);
        da.ready = 1'b1;
        tick();
        chk("bp_out_b", {48'd0, da.data}, 64'h0B);
        chk("bp_skid_empty", {63'd0, skid_full_a}, 64'd0);
        chk("bp_ready_back", {63'd0, ua.ready}, 64'd1);
        tick();
        chk("bp_out_c", {48'd0, da.data}, 64'h0C);
        ua.valid = 1'b0;
        tick();
        chk("bp_drained", {63'd0, da.valid}, 64'd0);
        chk("bp_stall_total", {48'd0, stall_a}, 64'd3);

        // flush while both entries are full, sticky survives
        da.ready = 1'b0; ua.valid = 1'b1; ua.data = 16'h0055; ua.sticky = 2'b01;
        tick();
        ua.data = 16'h0066; ua.sticky = 2'b10;
        tick();
        chk("fl_two", {63'd0, skid_full_a}, 64'd1);
        chk("fl_sticky_pre", {62'd0, da.sticky}, 64'd1);
        flush_a = 1'b1; ua.data = 16'h0099; ua.sticky = 2'b11;
        tick();
        chk("fl_dn_valid", {63'd0, da.valid}, 64'd0);
        chk("fl_skid_full", {63'd0, skid_full_a}, 64'd0);
        chk("fl_dn_data", {48'd0, da.data}, 64'd0);
        chk("fl_dn_sticky", {62'd0, da.sticky}, 64'd1);
        chk("fl_stall", {48'd0, stall_a}, 64'd4);
        flush_a = 1'b0; ua.valid = 1'b0;
        tick();
        chk("fl_dropped", {63'd0, da.valid}, 64'd0);
        chk("fl_up_ready", {63'd0, ua.ready}, 64'd1);

        // global enable low during a stall, flush inside is ignored
        ua.valid = 1'b1; ua.data = 16'h0012; ua.sticky = 2'b00;
        tick();
        ua.valid = 1'b0;
        tick();
        chk("en_stall_pre", {48'd0, stall_a}, 64'd5);
        cpu_en_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush_a = (i == 1);
            da.ready = (i == 2);
            tick();
            chk("en_up_ready", {63'd0, ua.ready}, 64'd0);
            chk("en_dn_valid", {63'd0, da.valid}, 64'd1);
            chk("en_dn_data", {48'd0, da.data}, 64'h12);
            chk("en_stall", {48'd0, stall_a}, 64'd5);
        end
        cpu_en_a = 1'b1; flush_a = 1'b0; da.ready = 1'b0;
        tick();
        chk("en_resume_stall", {48'd0, stall_a}, 64'd6);
        chk("en_resume_data", {48'd0, da.data}, 64'h12);
        da.ready = 1'b1;
        tick();
        chk("en_popped", {63'd0, da.valid}, 64'd0);

        // flush with a concurrent accept, payload held (instance B)
        db.ready = 1'b0; ub.valid = 1'b1; ub.data = 16'h0033; ub.sticky = 2'b10;
        tick();
        chk("hf_load", {48'd0, db.data}, 64'h33);
        flush_b = 1'b1; ub.data = 16'h0077; ub.sticky = 2'b01;
        tick();
        chk("hf_dn_valid", {63'd0, db.valid}, 64'd0);
        chk("hf_dn_data", {48'd0, db.data}, 64'h33);
        chk("hf_dn_sticky", {62'd0, db.sticky}, 64'd2);
        flush_b = 1'b0; ub.valid = 1'b0;
        tick();
        chk("hf_no_77", {48'd0, db.data}, 64'h33);
        chk("hf_empty", {63'd0, db.valid}, 64'd0);

        // 4-bit counter saturation and clear
        ub.valid = 1'b1; ub.data = 16'h0044;
        tick();
        chk("sat_start", {60'd0, stall_b}, 64'd0);
        ub.valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("sat_at_15", {60'd0, stall_b}, 64'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_held", {60'd0, stall_b}, 64'd15);
        clr_b = 1'b1;
        tick();
        chk("sat_clr", {60'd0, stall_b}, 64'd0);
        clr_b = 1'b0;
        tick();
        chk("sat_restart", {60'd0, stall_b}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
